// File: rtl/constants.sv
// constants: shared core-wide widths
package constants;
    localparam int DATA_WIDTH = 32;
endpackage

// File: rtl/mem_responder.sv
// mem_responder: credit-gated synchronous-RAM responder with fixed latency and an in-order response queue
module mem_responder #(
    parameter int DATA_WIDTH = constants::DATA_WIDTH,
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m_req_vld,
    output logic                  m_req_rdy,
    input  logic                  m_req_we,
    input  logic [ADDR_WIDTH-1:0] m_req_addr,
    input  logic [DATA_WIDTH-1:0] m_req_data,
    output logic                  m_rsp_vld,
    input  logic                  m_rsp_rdy,
    output logic [DATA_WIDTH-1:0] m_rsp_data,
    output logic                  m_rsp_we
);
    localparam int PW = $clog2(RSP_DEPTH) + 1;

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [LATENCY-1:0]    pv;
    logic [DATA_WIDTH-1:0] pd [LATENCY];
    logic                  pwe [LATENCY];
    logic [DATA_WIDTH-1:0] fd [RSP_DEPTH];
    logic                  fwe [RSP_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr, outstanding;
    logic                  acc, cons, empty;

    assign m_req_rdy  = outstanding < PW'(RSP_DEPTH);
    assign acc        = m_req_vld && m_req_rdy;
    assign empty      = wr_ptr == rd_ptr;
    assign m_rsp_vld  = !empty;
    assign cons       = m_rsp_vld && m_rsp_rdy;
    assign m_rsp_data = empty ? '0 : fd[rd_ptr[PW-2:0]];
    assign m_rsp_we   = !empty && fwe[rd_ptr[PW-2:0]];

    // Credits cover pipeline plus queue, so stages never stall and queue writes never drop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv          <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
        end else begin
            pv          <= LATENCY'({pv, acc});
            wr_ptr      <= wr_ptr + PW'(pv[LATENCY-1]);
            rd_ptr      <= rd_ptr + PW'(cons);
            outstanding <= outstanding + PW'(acc) - PW'(cons);
        end
    end

    // RAM and payload storage carry no reset; only the valid tags and pointers do
    always_ff @(posedge clk) begin
        if (acc && m_req_we) mem[m_req_addr] <= m_req_data;
        if (acc) begin
            pd[0]  <= m_req_we ? m_req_data : mem[m_req_addr];
            pwe[0] <= m_req_we;
        end
        for (int k = 1; k < LATENCY; k++) begin
            pd[k]  <= pd[k-1];
            pwe[k] <= pwe[k-1];
        end
        if (pv[LATENCY-1]) begin
            fd[wr_ptr[PW-2:0]]  <= pd[LATENCY-1];
            fwe[wr_ptr[PW-2:0]] <= pwe[LATENCY-1];
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of handshake, latency, backpressure, reset and queue wrap
module tb_mem_responder;
    logic        clk = 0, rst_n = 0;
    logic        m_req_vld = 0, m_req_we = 0, m_req_rdy;
    logic [7:0]  m_req_addr = 0;
    logic [31:0] m_req_data = 0;
    logic        m_rsp_vld, m_rsp_rdy = 0, m_rsp_we;
    logic [31:0] m_rsp_data;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .LATENCY(2), .RSP_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_req_vld(m_req_vld), .m_req_rdy(m_req_rdy), .m_req_we(m_req_we),
        .m_req_addr(m_req_addr), .m_req_data(m_req_data),
        .m_rsp_vld(m_rsp_vld), .m_rsp_rdy(m_rsp_rdy),
        .m_rsp_data(m_rsp_data), .m_rsp_we(m_rsp_we)
    );

    task automatic test_reset;
        rst_n = 0;
        @(negedge clk);
        n_cmp++; if (m_rsp_vld !== 1'b0) begin n_bad++; $display("FAIL rst_vld: got %b expected 0", m_rsp_vld); end
        n_cmp++; if (m_req_rdy !== 1'b1) begin n_bad++; $display("FAIL rst_rdy: got %b expected 1", m_req_rdy); end
        n_cmp++; if (m_rsp_data !== 32'h0) begin n_bad++; $display("FAIL rst_data: got %h expected 0", m_rsp_data); end
        n_cmp++; if (m_rsp_we !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b expected 0", m_rsp_we); end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic preload;
        m_rsp_rdy = 1;
        for (int i = 0; i < 16; i++) begin
            m_req_vld = 1; m_req_we = 1; m_req_addr = 8'(i); m_req_data = 32'h100 + i;
            @(negedge clk);
        end
        m_req_vld = 0; m_req_we = 0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int nxt = 0, got = 0, first = -1;
        bit gap = 0;
        m_rsp_rdy = 1;
        for (int c = 0; c < 40 && got < 16; c++) begin
            m_req_vld = nxt < 16; m_req_we = 0; m_req_addr = 8'(nxt);
            if (m_req_vld) begin
                n_cmp++; if (m_req_rdy !== 1'b1) begin n_bad++; $display("FAIL b2b_req_rdy: got %b expected 1 at cycle %0d", m_req_rdy, c); end
            end
            if (m_rsp_vld) begin
                n_cmp++; if (m_rsp_data !== 32'h100 + got || m_rsp_we !== 1'b0) begin
                    n_bad++; $display("FAIL b2b_rsp%0d: got %h/%b expected %h/0", got, m_rsp_data, m_rsp_we, 32'h100 + got);
                end
                if (first < 0) first = c;
                got++;
            end else if (first >= 0) gap = 1;
            if (m_req_vld && m_req_rdy) nxt++;
            @(negedge clk);
        end
        m_req_vld = 0;
        n_cmp++; if (got != 16) begin n_bad++; $display("FAIL b2b_count: got %0d expected 16", got); end
        n_cmp++; if (gap) begin n_bad++; $display("FAIL b2b_gap: got gap 1 expected 0"); end
        n_cmp++; if (first != 3) begin n_bad++; $display("FAIL b2b_first: got cycle %0d expected 3", first); end
    endtask

    task automatic test_backpressure;
        int nxt = 0, got = 0;
        logic [31:0] held = 0;
        bit have = 0, unstable = 0;
        m_rsp_rdy = 0;
        for (int c = 0; c < 8; c++) begin
            m_req_vld = 1; m_req_we = 0; m_req_addr = 8'(nxt);
            if (m_rsp_vld) begin
                if (!have) begin held = m_rsp_data; have = 1; end
                else if (m_rsp_data !== held) unstable = 1;
            end
            if (m_req_rdy) nxt++;
            @(negedge clk);
        end
        n_cmp++; if (nxt != 4) begin n_bad++; $display("FAIL bp_accepts: got %0d expected 4", nxt); end
        n_cmp++; if (m_req_rdy !== 1'b0) begin n_bad++; $display("FAIL bp_req_rdy: got %b expected 0", m_req_rdy); end
        n_cmp++; if (held !== 32'h100) begin n_bad++; $display("FAIL bp_head: got %h expected 00000100", held); end
        n_cmp++; if (unstable) begin n_bad++; $display("FAIL bp_stable: got changing data expected stable"); end
        m_rsp_rdy = 1;
        for (int c = 0; c < 30 && got < 6; c++) begin
            m_req_vld = nxt < 6; m_req_addr = 8'(nxt);
            if (m_rsp_vld) begin
                n_cmp++; if (m_rsp_data !== 32'h100 + got || m_rsp_we !== 1'b0) begin
                    n_bad++; $display("FAIL bp_rsp%0d: got %h/%b expected %h/0", got, m_rsp_data, m_rsp_we, 32'h100 + got);
                end
                got++;
            end
            if (m_req_vld && m_req_rdy) nxt++;
            @(negedge clk);
        end
        m_req_vld = 0;
        n_cmp++; if (got != 6 || nxt != 6) begin n_bad++; $display("FAIL bp_total: got %0d rsp/%0d acc expected 6/6", got, nxt); end
    endtask

    task automatic test_full_consume;
        int nxt = 0, got = 0;
        m_rsp_rdy = 0;
        for (int c = 0; c < 10; c++) begin
            m_req_vld = 1; m_req_we = 0; m_req_addr = 8'(nxt);
            if (m_req_rdy) nxt++;
            @(negedge clk);
        end
        n_cmp++; if (nxt != 4) begin n_bad++; $display("FAIL full_fill: got %0d expected 4", nxt); end
        n_cmp++; if (m_req_rdy !== 1'b0) begin n_bad++; $display("FAIL full_rdy: got %b expected 0", m_req_rdy); end
        n_cmp++; if (m_rsp_data !== 32'h100) begin n_bad++; $display("FAIL full_head: got %h expected 00000100", m_rsp_data); end
        m_rsp_rdy = 1; m_req_addr = 8'd4;
        @(negedge clk);
        m_rsp_rdy = 0;
        n_cmp++; if (m_req_rdy !== 1'b1) begin n_bad++; $display("FAIL full_rdy_back: got %b expected 1", m_req_rdy); end
        n_cmp++; if (m_rsp_data !== 32'h101) begin n_bad++; $display("FAIL full_head2: got %h expected 00000101", m_rsp_data); end
        @(negedge clk);
        m_req_vld = 0;
        n_cmp++; if (m_req_rdy !== 1'b0) begin n_bad++; $display("FAIL full_refill: got %b expected 0", m_req_rdy); end
        m_rsp_rdy = 1;
        for (int c = 0; c < 20 && got < 4; c++) begin
            if (m_rsp_vld) begin
                n_cmp++; if (m_rsp_data !== 32'h101 + got) begin n_bad++; $display("FAIL full_rsp%0d: got %h expected %h", got, m_rsp_data, 32'h101 + got); end
                got++;
            end
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        n_cmp++; if (got != 4 || m_rsp_vld !== 1'b0) begin n_bad++; $display("FAIL full_drain: got %0d rsp vld %b expected 4 vld 0", got, m_rsp_vld); end
    endtask

    task automatic test_write_read;
        m_rsp_rdy = 1;
        m_req_vld = 1; m_req_we = 1; m_req_addr = 8'd3; m_req_data = 32'hA5;
        @(negedge clk);
        m_req_we = 0; m_req_data = 0;
        @(negedge clk);
        m_req_vld = 0;
        n_cmp++; if (m_rsp_vld !== 1'b0) begin n_bad++; $display("FAIL wr_early: got vld %b expected 0", m_rsp_vld); end
        @(negedge clk);
        n_cmp++; if ({m_rsp_vld, m_rsp_we, m_rsp_data} !== {2'b11, 32'hA5}) begin
            n_bad++; $display("FAIL wr_ack: got vld %b we %b data %h expected 1 1 000000a5", m_rsp_vld, m_rsp_we, m_rsp_data);
        end
        @(negedge clk);
        n_cmp++; if ({m_rsp_vld, m_rsp_we, m_rsp_data} !== {2'b10, 32'hA5}) begin
            n_bad++; $display("FAIL rd_rsp: got vld %b we %b data %h expected 1 0 000000a5", m_rsp_vld, m_rsp_we, m_rsp_data);
        end
        @(negedge clk);
        n_cmp++; if (m_rsp_vld !== 1'b0) begin n_bad++; $display("FAIL wr_rd_idle: got vld %b expected 0", m_rsp_vld); end
    endtask

    task automatic test_reset_mid;
        int stale = 0;
        m_rsp_rdy = 1;
        m_req_vld = 1; m_req_we = 1; m_req_addr = 8'd20; m_req_data = 32'hDEADBEEF;
        @(negedge clk);
        m_req_vld = 0; m_req_we = 0;
        repeat (5) @(negedge clk);
        m_rsp_rdy = 0;
        for (int i = 0; i < 3; i++) begin
            m_req_vld = 1; m_req_addr = 8'(i);
            @(negedge clk);
        end
        m_req_vld = 0;
        repeat (3) @(negedge clk);
        n_cmp++; if (m_rsp_vld !== 1'b1) begin n_bad++; $display("FAIL rm_queued: got vld %b expected 1", m_rsp_vld); end
        #2 rst_n = 0;
        #1;
        n_cmp++; if (m_rsp_vld !== 1'b0 || m_req_rdy !== 1'b1) begin
            n_bad++; $display("FAIL rm_async: got vld %b rdy %b expected 0 1", m_rsp_vld, m_req_rdy);
        end
        n_cmp++; if (m_rsp_data !== 32'h0 || m_rsp_we !== 1'b0) begin
            n_bad++; $display("FAIL rm_outs: got data %h we %b expected 0 0", m_rsp_data, m_rsp_we);
        end
        @(negedge clk);
        rst_n = 1; m_rsp_rdy = 1;
        repeat (6) begin
            @(negedge clk);
            if (m_rsp_vld) stale++;
        end
        n_cmp++; if (stale != 0) begin n_bad++; $display("FAIL rm_stale: got %0d cycles valid expected 0", stale); end
        m_req_vld = 1; m_req_we = 0; m_req_addr = 8'd20;
        @(negedge clk);
        m_req_vld = 0;
        repeat (2) @(negedge clk);
        n_cmp++; if ({m_rsp_vld, m_rsp_we, m_rsp_data} !== {2'b10, 32'hDEADBEEF}) begin
            n_bad++; $display("FAIL rm_retain: got vld %b we %b data %h expected 1 0 deadbeef", m_rsp_vld, m_rsp_we, m_rsp_data);
        end
        @(negedge clk);
    endtask

    task automatic test_wrap;
        logic [31:0] mdl [4];
        logic [32:0] q [$];
        logic [31:0] exp_d;
        int i = 0, got = 0;
        for (int c = 0; c < 400 && got < 12; c++) begin
            m_rsp_rdy = 1'($urandom_range(0, 1));
            m_req_vld = i < 12;
            m_req_we = (i < 4) || (i % 2 == 0);
            m_req_addr = 8'(40 + i % 4);
            m_req_data = $urandom;
            if (m_rsp_vld && m_rsp_rdy) begin
                n_cmp++;
                if (q.size() == 0) begin n_bad++; $display("FAIL wrap_extra: got %h with no response expected", m_rsp_data); end
                else begin
                    if ({m_rsp_we, m_rsp_data} !== q[0]) begin
                        n_bad++; $display("FAIL wrap_rsp%0d: got %b/%h expected %b/%h", got, m_rsp_we, m_rsp_data, q[0][32], q[0][31:0]);
                    end
                    void'(q.pop_front());
                end
                got++;
            end
            if (m_req_vld && m_req_rdy) begin
                exp_d = m_req_we ? m_req_data : mdl[i % 4];
                if (m_req_we) mdl[i % 4] = m_req_data;
                q.push_back({m_req_we, exp_d});
                i++;
            end
            @(negedge clk);
        end
        m_req_vld = 0;
        n_cmp++; if (got != 12 || i != 12) begin n_bad++; $display("FAIL wrap_total: got %0d rsp/%0d acc expected 12/12", got, i); end
    endtask

    initial begin
        test_reset();
        preload();
        test_back_to_back();
        test_backpressure();
        test_full_consume();
        test_write_read();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
